deagg_src_arbiter: RTL and testbench

Round-robin arbiter that lets several wide-word sender FIFOs share a single deaggregator. It sits between NUM_SRC sender FIFOs (each presenting FETCH_WIDTH×DATA_WIDTH words with empty_n/deq handshakes) and the deaggregator's sender-side port. Arbitration is at whole-word granularity, with a bounded burst per grant. It also maintains a running count of words forwarded.

---
 rtl/deagg_src_arbiter.sv | 113 +++++++++++
 tb/tb_deagg_src_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deagg_src_arbiter.sv
// Round-robin arbiter that multiplexes several wide-word sender FIFOs onto one
// deaggregator sender port, granting whole words in bounded bursts.
module deagg_src_arbiter #(
    parameter int DATA_WIDTH  = 9,
    parameter int FETCH_WIDTH = 5,
    parameter int NUM_SRC     = 4,
    parameter int BURST_LEN   = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     enable,
    input  logic [NUM_SRC-1:0]                       src_mask,
    input  logic [NUM_SRC*FETCH_WIDTH*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]                       src_empty_n,
    output logic [NUM_SRC-1:0]                       src_deq,
    output logic [FETCH_WIDTH*DATA_WIDTH-1:0]        deagg_data,
    output logic                                     deagg_empty_n,
    input  logic                                     deagg_deq,
    output logic                                     grant_valid,
    output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] grant_id,
    output logic [15:0]                              word_count
);

    localparam int W     = FETCH_WIDTH * DATA_WIDTH;
    localparam int ID_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [ID_W-1:0]  last_id;
    logic [CNT_W-1:0] burst_cnt;

    logic [W-1:0]       src_words [NUM_SRC];
    logic [NUM_SRC-1:0] req;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    pick_id;
    logic               pick_found;
    logic               accept;
    logic               burst_done;
    logic               release_grant;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_split
        assign src_words[i] = src_data[i*W +: W];
    end

    // Circular first-set search starting just after the last released source.
    always_comb begin
        req        = src_empty_n & src_mask;
        cand       = '0;
        pick_id    = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = ID_W'((int'(last_id) + k) % NUM_SRC);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        src_deq       = '0;
        deagg_data    = '0;
        deagg_empty_n = 1'b0;
        if (state == GRANT) begin
            deagg_data        = src_words[grant_id];
            deagg_empty_n     = src_empty_n[grant_id];
            src_deq[grant_id] = deagg_deq & src_empty_n[grant_id];
        end
    end

    assign accept        = deagg_deq & deagg_empty_n;
    assign burst_done    = accept && (burst_cnt == CNT_W'(BURST_LEN - 1));
    assign release_grant = burst_done || !src_empty_n[grant_id] ||
                           !src_mask[grant_id] || !enable;
    assign grant_valid   = (state == GRANT);

    // Every release passes through IDLE, giving the one-cycle bubble between grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_id    <= ID_W'(NUM_SRC - 1);
            burst_cnt  <= '0;
            word_count <= '0;
        end else begin
            if (accept) begin
                word_count <= word_count + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (enable && pick_found) begin
                        grant_id  <= pick_id;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    if (release_grant) begin
                        state   <= IDLE;
                        last_id <= grant_id;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deagg_src_arbiter.sv
// Scoreboard bench for deagg_src_arbiter: directed scenarios push the expected
// (source, word index) stream, and a negedge monitor checks each dequeue.
module tb_deagg_src_arbiter;

    localparam int DW  = 9;
    localparam int FW  = 5;
    localparam int NS  = 4;
    localparam int BL  = 4;
    localparam int W   = DW * FW;
    localparam int IDW = 2;
    localparam int BIG = 1000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          enable;
    logic [NS-1:0] src_mask;
    logic [NS*W-1:0] src_data;
    logic [NS-1:0] src_empty_n;
    logic [NS-1:0] src_deq;
    logic [W-1:0]  deagg_data;
    logic          deagg_empty_n;
    logic          deagg_deq;
    logic          grant_valid;
    logic [IDW-1:0] grant_id;
    logic [15:0]   word_count;

    logic          w_enable;
    logic [NS-1:0] w_src_mask;
    logic [NS*W-1:0] w_src_data;
    logic [NS-1:0] w_src_empty_n;
    logic [NS-1:0] w_src_deq;
    logic [W-1:0]  w_deagg_data;
    logic          w_deagg_empty_n;
    logic          w_deagg_deq;
    logic          w_grant_valid;
    logic [IDW-1:0] w_grant_id;
    logic [15:0]   w_word_count;

    deagg_src_arbiter #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW), .NUM_SRC(NS), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .src_mask(src_mask),
        .src_data(src_data), .src_empty_n(src_empty_n), .src_deq(src_deq),
        .deagg_data(deagg_data), .deagg_empty_n(deagg_empty_n), .deagg_deq(deagg_deq),
        .grant_valid(grant_valid), .grant_id(grant_id), .word_count(word_count)
    );

    // Long bursts make the 16-bit wrap reachable in a modest number of cycles.
    deagg_src_arbiter #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW), .NUM_SRC(NS), .BURST_LEN(255)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .enable(w_enable), .src_mask(w_src_mask),
        .src_data(w_src_data), .src_empty_n(w_src_empty_n), .src_deq(w_src_deq),
        .deagg_data(w_deagg_data), .deagg_empty_n(w_deagg_empty_n), .deagg_deq(w_deagg_deq),
        .grant_valid(w_grant_valid), .grant_id(w_grant_id), .word_count(w_word_count)
    );

    typedef struct {
        int src;
        int widx;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   pulses = 0;
    int   wpulses = 0;
    int   src_load [NS];
    int   src_taken [NS];

    function automatic logic [W-1:0] make_word(input int s, input int w);
        logic [W-1:0] r;
        r = '0;
        for (int e = 0; e < FW; e++) begin
            r[e*DW +: DW] = {2'(s), 4'(w), 3'(e)};
        end
        return r;
    endfunction

    // Source FIFO model: word index advances on each dequeue strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) src_taken[i] <= 0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (src_deq[i]) src_taken[i] <= src_taken[i] + 1;
            end
        end
    end

    always_comb begin
        src_empty_n = '0;
        src_data    = '0;
        for (int i = 0; i < NS; i++) begin
            src_empty_n[i]     = (src_taken[i] < src_load[i]);
            src_data[i*W +: W] = make_word(i, src_taken[i]);
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_words(input int s, input int first, input int n);
        for (int k = 0; k < n; k++) sb.push_back('{s, first + k});
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (!deagg_deq) check_output("no_deq_without_sink", 64'(src_deq), 64'd0);
            if (|src_deq) begin
                pulses++;
                check_output("deq_onehot", 64'($onehot(src_deq)), 64'd1);
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_deq: got src_deq=%b, expected none at %0t", src_deq, $time);
                end else begin
                    mon_e = sb.pop_front();
                    check_output("grant_id", 64'(grant_id), 64'(mon_e.src));
                    check_output("deq_src", 64'(src_deq), 64'(1 << mon_e.src));
                    check_output("deagg_data", 64'(deagg_data), 64'(make_word(mon_e.src, mon_e.widx)));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && w_src_deq[0]) wpulses++;
    end

    task automatic apply_stimulus(input logic [NS-1:0] mask, input logic en, input logic deq);
        src_mask  = mask;
        enable    = en;
        deagg_deq = deq;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        apply_stimulus('0, 1'b0, 1'b0);
        for (int i = 0; i < NS; i++) src_load[i] = 0;
        w_enable = 1'b0; w_src_mask = '0; w_src_empty_n = '0; w_deagg_deq = 1'b0;
        wait_edges(2);
        rst_n = 1'b1;
        check_output("rst_grant_valid", 64'(grant_valid), 64'd0);
        check_output("rst_grant_id", 64'(grant_id), 64'd0);
        check_output("rst_word_count", 64'(word_count), 64'd0);
        check_output("rst_empty_n", 64'(deagg_empty_n), 64'd0);
        check_output("rst_data", 64'(deagg_data), 64'd0);
    endtask

    task automatic finish_test(input string name);
        apply_stimulus(src_mask, 1'b0, 1'b0);
        wait_edges(2);
        check_output({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int base;
        int n_cyc;
        rst_n = 1'b1;
        w_src_data = '0;
        for (int i = 0; i < NS; i++) src_load[i] = 0;
        apply_stimulus('0, 1'b0, 1'b0);

        // Single source: 4 words, bubble, 4 words in 10 cycles.
        apply_reset();
        src_load[2] = BIG;
        apply_stimulus(4'b0100, 1'b1, 1'b1);
        expect_words(2, 0, 8);
        wait_edges(10);
        check_output("single_word_count", 64'(word_count), 64'd8);
        check_output("single_bubble", 64'(grant_valid), 64'd0);
        finish_test("single");

        // Full load: grants 0,1,2,3,0 with four words each.
        apply_reset();
        for (int i = 0; i < NS; i++) src_load[i] = BIG;
        apply_stimulus(4'b1111, 1'b1, 1'b1);
        expect_words(0, 0, 4); expect_words(1, 0, 4); expect_words(2, 0, 4);
        expect_words(3, 0, 4); expect_words(0, 4, 4);
        wait_edges(25);
        check_output("rr_word_count", 64'(word_count), 64'd20);
        finish_test("rr");

        // Early release on empty source, then a fresh full burst.
        apply_reset();
        src_load[1] = 2;
        apply_stimulus(4'b1111, 1'b1, 1'b1);
        expect_words(1, 0, 2);
        wait_edges(4);
        check_output("early_released", 64'(grant_valid), 64'd0);
        src_load[1] = 8;
        expect_words(1, 2, 6);
        wait_edges(3);
        check_output("early_burst_cleared", 64'(grant_valid), 64'd1);
        wait_edges(2);
        check_output("early_burst_bubble", 64'(grant_valid), 64'd0);
        wait_edges(4);
        check_output("early_final_idle", 64'(grant_valid), 64'd0);
        check_output("early_word_count", 64'(word_count), 64'd8);
        finish_test("early");

        // Mask drop after one word, then enable drop.
        apply_reset();
        src_load[0] = BIG; src_load[1] = BIG;
        apply_stimulus(4'b0011, 1'b1, 1'b1);
        expect_words(0, 0, 1);
        wait_edges(1);
        src_mask = 4'b0010;
        expect_words(1, 0, 2);
        wait_edges(1);
        check_output("mask_release", 64'(grant_valid), 64'd0);
        check_output("mask_word_counted", 64'(word_count), 64'd1);
        wait_edges(1);
        check_output("mask_regrant_valid", 64'(grant_valid), 64'd1);
        check_output("mask_regrant_id", 64'(grant_id), 64'd1);
        wait_edges(1);
        enable = 1'b0;
        wait_edges(1);
        check_output("en_release", 64'(grant_valid), 64'd0);
        check_output("en_word_count", 64'(word_count), 64'd3);
        wait_edges(3);
        check_output("en_hold_count", 64'(word_count), 64'd3);
        check_output("en_idle_empty_n", 64'(deagg_empty_n), 64'd0);
        check_output("en_idle_data", 64'(deagg_data), 64'd0);
        finish_test("mask");

        // Backpressure: random sink, order still 0,1,2,3 with four words each.
        apply_reset();
        for (int i = 0; i < NS; i++) src_load[i] = BIG;
        apply_stimulus(4'b1111, 1'b1, 1'b0);
        expect_words(0, 0, 4); expect_words(1, 0, 4); expect_words(2, 0, 4); expect_words(3, 0, 4);
        base = pulses;
        n_cyc = 0;
        while ((pulses - base) < 16 && n_cyc < 300) begin
            deagg_deq = 1'($urandom_range(0, 1));
            wait_edges(1);
            n_cyc++;
        end
        deagg_deq = 1'b0;
        check_output("bp_within_budget", 64'(n_cyc < 300), 64'd1);
        check_output("bp_word_count", 64'(word_count), 64'd16);
        check_output("bp_count_vs_pulses", 64'(word_count), 64'(pulses - base));
        finish_test("bp");

        // Wrap: 65536+3 words on the long-burst instance.
        apply_reset();
        w_src_mask = 4'b0001; w_src_empty_n = '1; w_enable = 1'b1; w_deagg_deq = 1'b1;
        n_cyc = 0;
        while (wpulses < 65539 && n_cyc < 70000) begin
            wait_edges(1);
            n_cyc++;
        end
        w_deagg_deq = 1'b0; w_enable = 1'b0;
        check_output("wrap_within_budget", 64'(n_cyc < 70000), 64'd1);
        check_output("wrap_word_count", 64'(w_word_count), 64'd3);

        // Reset asserted mid-grant takes effect without a clock edge.
        apply_reset();
        src_load[1] = BIG;
        apply_stimulus(4'b0010, 1'b1, 1'b1);
        expect_words(1, 0, 2);
        wait_edges(3);
        check_output("pre_rst_count", 64'(word_count), 64'd2);
        check_output("pre_rst_deq", 64'(src_deq), 64'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_grant_valid", 64'(grant_valid), 64'd0);
        check_output("async_grant_id", 64'(grant_id), 64'd0);
        check_output("async_word_count", 64'(word_count), 64'd0);
        check_output("async_src_deq", 64'(src_deq), 64'd0);
        check_output("async_empty_n", 64'(deagg_empty_n), 64'd0);
        check_output("async_data", 64'(deagg_data), 64'd0);
        apply_stimulus('0, 1'b0, 1'b0);
        wait_edges(2);
        rst_n = 1'b1;
        check_output("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
